// File: rtl/gpio_input_conditioner.sv
// 32-pin input conditioner: two-flop synchronizer, per-bit debounce, optional edge interrupts.
// Define GPIO_INPUT_CONDITIONER_INT_EN to build the edge-interrupt logic; otherwise int outputs are 0.
module gpio_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_raw,
  output logic [31:0] gpio_clean,
  input  logic [31:0] int_rise_en,
  input  logic [31:0] int_fall_en,
  input  logic [31:0] int_clear,
  output logic [31:0] int_pending,
  output logic        gpio_int
);

  localparam logic [15:0] THRESH = 16'(DEBOUNCE_CYCLES - 1);

  logic [31:0] sync1;
  logic [31:0] sync2;
  logic [31:0] clean_q;
  logic [15:0] cnt_q [32];

  // The counter only runs while sync2 disagrees with clean_q, and it clears on the
  // accepting edge, so it tops out at THRESH and can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      clean_q <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      sync1 <= gpio_raw;
      sync2 <= sync1;
      for (int i = 0; i < 32; i++) begin
        if (sync2[i] == clean_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == THRESH) begin
          clean_q[i] <= sync2[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign gpio_clean = clean_q;

`ifdef GPIO_INPUT_CONDITIONER_INT_EN
  logic [31:0] prev_q;
  logic [31:0] pending_q;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] set_mask;

  assign rise     = clean_q & ~prev_q;
  assign fall     = ~clean_q & prev_q;
  assign set_mask = (rise & int_rise_en) | (fall & int_fall_en);

  // prev_q resets alongside clean_q, so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= clean_q;
      pending_q <= (pending_q & ~int_clear) | set_mask;
    end
  end

  assign int_pending = pending_q;
  assign gpio_int    = |pending_q;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{int_rise_en, int_fall_en, int_clear};
  assign int_pending       = '0;
  assign gpio_int          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4.
// Interrupt expectations follow whether GPIO_INPUT_CONDITIONER_INT_EN is defined.
module tb_gpio_input_conditioner;

`ifdef GPIO_INPUT_CONDITIONER_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] gpio_raw;
  logic [31:0] gpio_clean;
  logic [31:0] int_rise_en;
  logic [31:0] int_fall_en;
  logic [31:0] int_clear;
  logic [31:0] int_pending;
  logic        gpio_int;

  int n_checks;
  int n_fail;

  gpio_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_raw    (gpio_raw),
    .gpio_clean  (gpio_clean),
    .int_rise_en (int_rise_en),
    .int_fall_en (int_fall_en),
    .int_clear   (int_clear),
    .int_pending (int_pending),
    .gpio_int    (gpio_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] re;
    logic [31:0] fe;
    logic [31:0] clr;
    logic [31:0] exp_clean;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs [10];

  // scoreboard: compares outputs 1 time unit after the edge that produced them
  task automatic check(input logic [31:0] exp_clean, input logic [31:0] exp_pend, input string name);
    logic [31:0] exp_p;
    logic        exp_i;
    exp_p = INT_ON ? exp_pend : 32'h0;
    exp_i = |exp_p;
    n_checks++;
    if (gpio_clean !== exp_clean) begin
      n_fail++;
      $display("FAIL %s gpio_clean got %h want %h", name, gpio_clean, exp_clean);
    end
    n_checks++;
    if (int_pending !== exp_p) begin
      n_fail++;
      $display("FAIL %s int_pending got %h want %h", name, int_pending, exp_p);
    end
    n_checks++;
    if (gpio_int !== exp_i) begin
      n_fail++;
      $display("FAIL %s gpio_int got %b want %b", name, gpio_int, exp_i);
    end
  endtask

  // driver: apply inputs, clock once, check the result of that edge
  task automatic step(input logic [31:0] raw, input logic [31:0] re, input logic [31:0] fe,
                      input logic [31:0] clr, input logic [31:0] exp_clean,
                      input logic [31:0] exp_pend, input string name);
    gpio_raw    = raw;
    int_rise_en = re;
    int_fall_en = fe;
    int_clear   = clr;
    @(posedge clk);
    #1;
    check(exp_clean, exp_pend, name);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    gpio_raw    = '0;
    int_rise_en = '0;
    int_fall_en = '0;
    int_clear   = '0;

    // bit 0 rises: clean after 6 edges, pending one edge later, then cleared
    for (int k = 0; k < 5; k++) vecs[k] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
    vecs[6] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};
    vecs[7] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};
    vecs[8] = '{32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0};
    vecs[9] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};

    step(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, "reset_c1");
    step(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, "reset_c2");
    rst = 1'b0;

    for (int k = 0; k < 10; k++)
      step(vecs[k].raw, vecs[k].re, vecs[k].fe, vecs[k].clr,
           vecs[k].exp_clean, vecs[k].exp_pend, $sformatf("b0_rise_v%0d", k));

    // bit 3 glitches of 3 cycles must never accumulate to an accept
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) step(32'h9, 32'h9, 32'h0, 32'h0, 32'h1, 32'h0, "glitch_hi");
      for (int k = 0; k < 3; k++) step(32'h1, 32'h9, 32'h0, 32'h0, 32'h1, 32'h0, "glitch_lo");
    end

    // bit 3 held: full latency from a cleared counter
    for (int k = 1; k <= 6; k++)
      step(32'h9, 32'h9, 32'h0, 32'h0, (k == 6) ? 32'h9 : 32'h1, 32'h0, "b3_hold");
    step(32'h9, 32'h9, 32'h0, 32'h0, 32'h9, 32'h8, "b3_pend");
    step(32'h9, 32'h9, 32'h0, 32'h8, 32'h9, 32'h0, "b3_clear");

    // bit 31: rise not enabled, fall enabled; clear on the set cycle loses
    for (int k = 1; k <= 6; k++)
      step(32'h80000009, 32'h0, 32'h80000000, 32'h0,
           (k == 6) ? 32'h80000009 : 32'h9, 32'h0, "b31_rise");
    step(32'h80000009, 32'h0, 32'h80000000, 32'h0, 32'h80000009, 32'h0, "b31_rise_nopend");
    for (int k = 1; k <= 6; k++)
      step(32'h9, 32'h0, 32'h80000000, 32'h0,
           (k == 6) ? 32'h9 : 32'h80000009, 32'h0, "b31_fall");
    step(32'h9, 32'h0, 32'h80000000, 32'h80000000, 32'h9, 32'h80000000, "set_wins");
    step(32'h9, 32'h0, 32'h0, 32'h0, 32'h9, 32'h80000000, "en_change_keeps");
    step(32'h9, 32'h0, 32'h0, 32'h80000000, 32'h9, 32'h0, "b31_clear");

    // reset mid-debounce, then all 32 bits rise together
    for (int k = 0; k < 3; k++)
      step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h9, 32'h0, "pre_reset");
    rst = 1'b1;
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, "mid_reset");
    rst = 1'b0;
    for (int k = 1; k <= 6; k++)
      step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
           (k == 6) ? 32'hFFFFFFFF : 32'h0, 32'h0, "all_rise");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, "all_pend");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, "all_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
